// File: rtl/pipo_load_arbiter_pkg.sv
// Shared types and default parameters for the PIPO load arbiter slice.
// Used by pipo_load_arbiter and its holding-register sub-module.
package pipo_arb_pkg;

  localparam int unsigned DEF_WIDTH       = 4;
  localparam int unsigned DEF_N_REQ       = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/pipo_load_arbiter_reg.sv
// WIDTH-bit parallel-in/parallel-out holding register with synchronous
// active-high reset and load enable.
module pipo_reg
  import pipo_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter loading one of N_REQ requester words into a shared
// PIPO register, held for at least HOLD_CYCLES until the consumer accepts it.
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned N_REQ       = DEF_N_REQ,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ack,
  output logic [WIDTH-1:0]         q_out,
  output logic [$clog2(N_REQ)-1:0] out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_rr_ptr;
  logic [CW-1:0]    r_hold_cnt;
  logic [IW-1:0]    r_out_src;
  logic             r_out_valid;

  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_win;
  logic             w_found;
  logic             w_grant;
  logic             w_hold_done;
  logic             w_load;
  logic [WIDTH-1:0] w_win_data;

  // Rotating priority: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = IW'((32'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_grant     = (r_state == ST_IDLE) && w_found && !rst_;
  assign w_hold_done = (r_hold_cnt == HOLD_LAST) && out_ready;
  assign w_win_data  = req_data[32'(w_win)*WIDTH +: WIDTH];

  always_comb begin
    req_ack = '0;
    if (w_grant) begin
      req_ack[w_win] = 1'b1;
    end
  end

  assign w_load = |req_ack;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)     w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_hold_done) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_hold_cnt  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_out_src   <= w_win;
        r_out_valid <= 1'b1;
        r_hold_cnt  <= '0;
        r_rr_ptr    <= (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
      end else if (r_state == ST_HOLD) begin
        if (w_hold_done) begin
          r_out_valid <= 1'b0;
          r_hold_cnt  <= '0;
        end else if (r_hold_cnt != HOLD_LAST) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  pipo_reg #(
    .WIDTH(WIDTH)
  ) u_q_reg (
    .i_clk (clk),
    .i_rst (rst_),
    .i_load(w_load),
    .i_d   (w_win_data),
    .o_q   (q_out)
  );

  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == ST_HOLD) && !rst_;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Self-checking bench for pipo_load_arbiter (WIDTH=4, N_REQ=4, HOLD_CYCLES=2):
// a per-cycle vector table plus directed multi-cycle sequences.
module tb_pipo_load_arbiter;

  logic        clk;
  logic        rst_;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ack;
  logic [3:0]  q_out;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  pipo_load_arbiter #(
    .WIDTH(4),
    .N_REQ(4),
    .HOLD_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ack  (req_ack),
    .q_out    (q_out),
    .out_src  (out_src),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic       rdy;
    logic [3:0] ack;
    logic [3:0] q;
    logic [1:0] src;
    logic       ov;
    logic       bsy;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic rst, input logic [3:0] rv, input logic rdy,
                              input logic [3:0] ack, input logic [3:0] q,
                              input logic [1:0] src, input logic ov, input logic bsy);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rdy = rdy;
    v.ack = ack; v.q = q; v.src = src; v.ov = ov; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_all(input string tag, input logic [3:0] ack, input logic [3:0] q,
                            input logic [1:0] src, input logic ov, input logic bsy);
    chk({tag, ".req_ack"},   32'(req_ack),   32'(ack));
    chk({tag, ".q_out"},     32'(q_out),     32'(q));
    chk({tag, ".out_src"},   32'(out_src),   32'(src));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".busy"},      32'(busy),      32'(bsy));
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic rst, input logic [3:0] rv, input logic rdy);
    @(posedge clk);
    #1;
    rst_      = rst;
    req_valid = rv;
    out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst_      = 1'b1;
    req_valid = 4'b0000;
    req_data  = 16'hFB97;
    out_ready = 1'b1;
    @(posedge clk);

    // Single requester, then all four in rotation (one word per 3 cycles).
    tbl[0]  = mk(1, 4'b0000, 1, 4'b0000, 4'h0, 0, 0, 0);
    tbl[1]  = mk(0, 4'b0001, 1, 4'b0001, 4'h0, 0, 0, 0);
    tbl[2]  = mk(0, 4'b0000, 1, 4'b0000, 4'h7, 0, 1, 1);
    tbl[3]  = mk(0, 4'b0000, 1, 4'b0000, 4'h7, 0, 1, 1);
    tbl[4]  = mk(0, 4'b0000, 1, 4'b0000, 4'h7, 0, 0, 0);
    tbl[5]  = mk(1, 4'b1111, 1, 4'b0000, 4'h7, 0, 0, 0);
    tbl[6]  = mk(0, 4'b1111, 1, 4'b0001, 4'h0, 0, 0, 0);
    tbl[7]  = mk(0, 4'b1110, 1, 4'b0000, 4'h7, 0, 1, 1);
    tbl[8]  = mk(0, 4'b1110, 1, 4'b0000, 4'h7, 0, 1, 1);
    tbl[9]  = mk(0, 4'b1110, 1, 4'b0010, 4'h7, 0, 0, 0);
    tbl[10] = mk(0, 4'b1100, 1, 4'b0000, 4'h9, 1, 1, 1);
    tbl[11] = mk(0, 4'b1100, 1, 4'b0000, 4'h9, 1, 1, 1);
    tbl[12] = mk(0, 4'b1100, 1, 4'b0100, 4'h9, 1, 0, 0);
    tbl[13] = mk(0, 4'b1000, 1, 4'b0000, 4'hB, 2, 1, 1);
    tbl[14] = mk(0, 4'b1000, 1, 4'b0000, 4'hB, 2, 1, 1);
    tbl[15] = mk(0, 4'b1000, 1, 4'b1000, 4'hB, 2, 0, 0);
    tbl[16] = mk(0, 4'b0000, 1, 4'b0000, 4'hF, 3, 1, 1);
    tbl[17] = mk(0, 4'b0000, 1, 4'b0000, 4'hF, 3, 1, 1);
    tbl[18] = mk(0, 4'b0000, 1, 4'b0000, 4'hF, 3, 0, 0);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].rdy);
      expect_all($sformatf("vec%0d", i), tbl[i].ack, tbl[i].q, tbl[i].src, tbl[i].ov, tbl[i].bsy);
    end

    // Consumer stall: word held, no acks while requester 1 waits.
    drive(0, 4'b0001, 0); expect_all("stall_load", 4'b0001, 4'hF, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'b0010, 0); expect_all($sformatf("stall%0d", i), 4'b0000, 4'h7, 0, 1, 1);
    end
    drive(0, 4'b0010, 1); expect_all("stall_release", 4'b0000, 4'h7, 0, 1, 1);
    drive(0, 4'b0010, 1); expect_all("stall_idle",    4'b0010, 4'h7, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b0000, 1); expect_all("stall_hold9", 4'b0000, 4'h9, 1, 1, 1);
    end

    // Pointer wrap: grant 2 sets pointer to 3, then 1001 goes to 3 before 0.
    drive(0, 4'b0100, 1); expect_all("wrap_g2", 4'b0100, 4'h9, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b1001, 1); expect_all("wrap_hB", 4'b0000, 4'hB, 2, 1, 1);
    end
    drive(0, 4'b1001, 1); expect_all("wrap_g3", 4'b1000, 4'hB, 2, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b0001, 1); expect_all("wrap_hF", 4'b0000, 4'hF, 3, 1, 1);
    end
    drive(0, 4'b0001, 1); expect_all("wrap_g0", 4'b0001, 4'hF, 3, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b0000, 1); expect_all("wrap_h7", 4'b0000, 4'h7, 0, 1, 1);
    end
    drive(0, 4'b0011, 1); expect_all("wrap_ptr1", 4'b0010, 4'h7, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b0001, 1); expect_all("wrap_h9", 4'b0000, 4'h9, 1, 1, 1);
    end
    drive(0, 4'b0001, 1); expect_all("wrap_search", 4'b0001, 4'h9, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b0000, 1); expect_all("wrap_h7b", 4'b0000, 4'h7, 0, 1, 1);
    end

    // Reset while holding 4'hB; pointer returns to 0 so 1001 grants 0.
    drive(0, 4'b0100, 1); expect_all("rst_g2",   4'b0100, 4'h7, 0, 0, 0);
    drive(1, 4'b1001, 1); expect_all("rst_on",   4'b0000, 4'hB, 2, 1, 0);
    drive(0, 4'b1001, 1); expect_all("rst_off",  4'b0001, 4'h0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b1000, 1); expect_all("rst_h7", 4'b0000, 4'h7, 0, 1, 1);
    end
    drive(0, 4'b1000, 1); expect_all("rst_g3",   4'b1000, 4'h7, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b0000, 1); expect_all("rst_hF", 4'b0000, 4'hF, 3, 1, 1);
    end

    // Requester 2 withdraws before its turn; 1 and 3 still served.
    drive(0, 4'b0111, 1); expect_all("drop_g0", 4'b0001, 4'hF, 3, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b0110, 1); expect_all("drop_h7", 4'b0000, 4'h7, 0, 1, 1);
    end
    drive(0, 4'b0010, 1); expect_all("drop_g1", 4'b0010, 4'h7, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b1000, 1); expect_all("drop_h9", 4'b0000, 4'h9, 1, 1, 1);
    end
    drive(0, 4'b1000, 1); expect_all("drop_g3", 4'b1000, 4'h9, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b0000, 1); expect_all("drop_hF", 4'b0000, 4'hF, 3, 1, 1);
    end
    drive(0, 4'b0000, 1); expect_all("drop_idle", 4'b0000, 4'hF, 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
